// File: rtl/tick_gen_pkg.sv
// Shared types for the multi-channel tick generator.
// Channel FSM states and mode encodings.
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_gen_chan.sv
// One tick generator channel: counter, terminal-count register and IDLE/RUN/DONE FSM.
// TICK_GEN_ONESHOT_EN enables the one-shot mode and the DONE state.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEFAULT_TC = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             tc_load,
  input  logic [WIDTH-1:0] tc_data,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  tick_state_t      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tc_q    <= WIDTH'(DEFAULT_TC);
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      tick_q  <= tick_d;
    end
  end

  // The enabling edge already counts as a run step from count 0, so the
  // first tick lands TC edges later and TC=0 ticks immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    tc_d    = tc_load ? tc_data : tc_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= tc_q) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          state_d = RUN;
`ifdef TICK_GEN_ONESHOT_EN
          if (mode == MODE_ONESHOT) state_d = DONE;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RUN;
        end
      end
`ifdef TICK_GEN_ONESHOT_EN
      DONE: begin
        cnt_d = '0;
        if (!en) state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifndef TICK_GEN_ONESHOT_EN
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign tick  = tick_q;
  assign busy  = (state_q == RUN);
  assign count = cnt_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: tc_sel decode and output packing.
// Define TICK_GEN_ONESHOT_EN to honour the per-channel one-shot mode.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int  WIDTH      = 4,
  parameter int  CHANNELS   = 2,
  parameter int  DEFAULT_TC = 11,
  localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic                      tc_wr,
  input  logic [SELW-1:0]           tc_sel,
  input  logic [WIDTH-1:0]          tc_data,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] count
);

  // Out-of-range selects match no channel and are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic load;
    assign load = tc_wr && (tc_sel == SELW'(c));

    tick_gen_chan #(
      .WIDTH     (WIDTH),
      .DEFAULT_TC(DEFAULT_TC)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[c]),
      .mode   (mode[c]),
      .tc_load(load),
      .tc_data(tc_data),
      .tick   (tick[c]),
      .busy   (busy[c]),
      .count  (count[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the channel rules.
module tb_tick_gen;
  localparam int W   = 4;
  localparam int CH  = 3;
  localparam int DTC = 11;
  localparam int SW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, mode, tick, busy;
  logic            tc_wr;
  logic [SW-1:0]   tc_sel;
  logic [W-1:0]    tc_data;
  logic [CH*W-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n;

  tick_gen #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_TC(DTC)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .tc_wr(tc_wr),
    .tc_sel(tc_sel), .tc_data(tc_data), .tick(tick), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model: per channel a position within the period, its TC,
  // whether it is running, and whether a one-shot has been spent.
  int m_cnt[CH];
  int m_tc[CH];
  bit m_run[CH];
  bit m_spent[CH];
  bit m_tick[CH];

  function automatic bit oneshot_on();
`ifdef TICK_GEN_ONESHOT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_tc[c] = DTC; m_run[c] = 0; m_spent[c] = 0; m_tick[c] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      int new_tc;
      new_tc = (tc_wr && int'(tc_sel) == c) ? int'(tc_data) : m_tc[c];
      m_tick[c] = 0;
      if (!en[c]) begin
        m_run[c] = 0; m_spent[c] = 0; m_cnt[c] = 0;
      end else if (!m_spent[c]) begin
        m_run[c] = 1;
        if (m_cnt[c] >= m_tc[c]) begin
          m_tick[c] = 1;
          m_cnt[c]  = 0;
          if (oneshot_on() && mode[c]) begin
            m_run[c] = 0; m_spent[c] = 1;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      m_tc[c] = new_tc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
      check($sformatf("busy[%0d]", c), 32'(busy[c]), 32'(m_run[c]));
      check($sformatf("count[%0d]", c), 32'(count[c*W +: W]), 32'(m_cnt[c]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic write_tc(input int sel, input int data);
    tc_wr = 1'b1; tc_sel = SW'(sel); tc_data = W'(data);
    cycle();
    tc_wr = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int max, output int cycles);
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      cycle();
      cycles++;
      if (tick[ch]) return;
    end
    vectors++; miscompares++;
    $display("FAIL wait_tick[%0d]: no tick within %0d cycles", ch, max);
  endtask

  task automatic wait_count(input int ch, input int val, input int max);
    for (int i = 0; i < max; i++) begin
      if (int'(count[ch*W +: W]) == val) return;
      cycle();
    end
    vectors++; miscompares++;
    $display("FAIL wait_count[%0d]: count %0d not reached in %0d cycles", ch, val, max);
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = '0; tc_wr = 1'b0; tc_sel = '0; tc_data = '0;
    model_reset();
    #2;
    check("reset tick", 32'(tick), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset count", 32'(count), 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Default TC=11: first tick 12 edges after enable, then 12-cycle period.
    en = 3'b001;
    wait_tick(0, 40, n); check("first tick latency", n, 12);
    wait_tick(0, 40, n); check("default period", n, 12);

    // Shrinking TC below the count wraps on the following compare.
    wait_count(0, 9, 20);
    write_tc(0, 5);
    check("count after shrink write", 32'(count[3:0]), 32'd10);
    wait_tick(0, 5, n); check("shrink tick", n, 1);
    wait_tick(0, 20, n); check("shrunk period", n, 6);

    // Write collides with a wrap: the wrap uses the old TC.
    write_tc(0, 11);
    wait_count(0, 11, 20);
    write_tc(0, 2);
    check("collision tick", 32'(tick[0]), 32'd1);
    wait_tick(0, 10, n); check("post-collision period", n, 3);
    wait_count(0, 2, 10);
    write_tc(0, 11);
    check("old TC used on collision", 32'(tick[0]), 32'd1);
    wait_tick(0, 20, n); check("regrown period", n, 12);

    // Out-of-range select is ignored.
    write_tc(3, 1);
    wait_tick(0, 20, n);
    wait_tick(0, 20, n); check("period after bad sel write", n, 12);

    // Abort mid-period.
    wait_count(0, 7, 20);
    en = 3'b000;
    cycle();
    check("abort count", 32'(count[3:0]), 32'd0);
    check("abort tick", 32'(tick[0]), 32'd0);
    check("abort busy", 32'(busy[0]), 32'd0);

    // One-shot (periodic when the feature is compiled out).
    write_tc(1, 3);
    mode = 3'b010; en = 3'b010;
    wait_tick(1, 10, n); check("oneshot first tick", n, 4);
`ifdef TICK_GEN_ONESHOT_EN
    repeat (10) cycle();
    check("oneshot busy low", 32'(busy[1]), 32'd0);
    en = 3'b000;
    cycle();
    en = 3'b010;
    wait_tick(1, 10, n); check("oneshot rearm", n, 4);
`else
    wait_tick(1, 10, n); check("mode ignored period", n, 4);
`endif
    en = 3'b000; mode = 3'b000;
    cycle();

    // Async reset on a tick-high cycle; TC must return to the default.
    write_tc(0, 4);
    en = 3'b001;
    wait_tick(0, 20, n);
    #1 rst = 1'b1;
    #1;
    check("async reset tick", 32'(tick), 32'd0);
    check("async reset count", 32'(count), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    wait_tick(0, 40, n); check("TC default after reset", n, 12);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
      end
      tc_wr   = ($urandom_range(0, 7) == 0);
      tc_sel  = SW'($urandom_range(0, 3));
      tc_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 4));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
